// File: rtl/uart_tx_fifo_if.sv
// Transmit-side word handshake between a producer and the UART transmit FIFO.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
    parameter int WORD_LENGTH = 8
);
    logic [WORD_LENGTH-1:0] tx_data;
    logic                   tx_data_valid;
    logic                   tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two word FIFO; frames go out back-to-back
// with every bit lasting exactly CLKRATE/BAUD clock cycles.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLKRATE     = 100000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_fifo_if.slave                   tx_if,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            UART_TX
);
    localparam int BAUD_DIV = CLKRATE / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(WORD_LENGTH - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLKRATE/BAUD must be at least 2");
    end
    if (WORD_LENGTH < 5 || WORD_LENGTH > 9) begin : g_bad_word
        $error("uart_tx_fifo: WORD_LENGTH must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [WORD_LENGTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    state_t                 r_state;
    logic [BW-1:0]          r_baud_cnt;
    logic [3:0]             r_bit_cnt;
    logic [WORD_LENGTH-1:0] r_shift;
    logic                   r_parity;
    logic                   r_tx;

    state_t                 w_state_next;
    logic [BW-1:0]          w_baud_next;
    logic [3:0]             w_bit_next;
    logic [WORD_LENGTH-1:0] w_shift_next;
    logic                   w_parity_next;
    logic                   w_tx_next;
    logic                   w_frame_start;
    logic                   w_bit_end;
    logic                   w_nonempty;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;

    assign w_ready               = !rst && (r_count != FULL);
    assign w_push                = tx_if.tx_data_valid && w_ready;
    assign w_nonempty            = (r_count != '0);
    assign w_bit_end             = (r_baud_cnt == BAUD_LAST);
    assign tx_if.tx_data_ready   = w_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = w_bit_end ? '0 : r_baud_cnt + BW'(1);
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_frame_start = 1'b0;
        w_pop         = 1'b0;
        w_tx_next     = 1'b1;

        case (r_state)
            IDLE: begin
                w_baud_next   = '0;
                w_frame_start = w_nonempty;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_bit_next   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_state_next = (PARITY_MODE != 0) ? PARITY : STOP;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next   = r_bit_cnt + 4'd1;
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_bit_next   = '0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_frame_start = w_nonempty;
                        w_state_next  = IDLE;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Popping the head here is what lets the next start bit follow the last stop bit directly.
        if (w_frame_start) begin
            w_state_next  = START;
            w_pop         = 1'b1;
            w_baud_next   = '0;
            w_bit_next    = '0;
            w_shift_next  = r_mem[r_rd_ptr];
            w_parity_next = (^r_mem[r_rd_ptr]) ^ ODD_PAR;
        end

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_parity;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
        end
    end

    assign UART_TX    = r_tx;
    assign tx_busy    = (r_state != IDLE);
    assign fifo_count = r_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three transmitters (even parity, odd parity, no parity + 2 stop bits) share one
// stimulus and are checked every cycle against a queue-of-line-samples model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int BDIV  = 10;
    localparam int NBITS = 11;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = '0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.WORD_LENGTH(8)) if_a ();
    uart_tx_fifo_if #(.WORD_LENGTH(8)) if_b ();
    uart_tx_fifo_if #(.WORD_LENGTH(8)) if_c ();

    assign if_a.tx_data = data;
    assign if_b.tx_data = data;
    assign if_c.tx_data = data;
    assign if_a.tx_data_valid = valid;
    assign if_b.tx_data_valid = valid;
    assign if_c.tx_data_valid = valid;

    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    uart_tx_fifo #(.CLKRATE(1000), .BAUD(100), .WORD_LENGTH(8), .PARITY_MODE(1),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .tx_if(if_a), .tx_busy(busy_a), .fifo_count(cnt_a), .UART_TX(tx_a));
    uart_tx_fifo #(.CLKRATE(1000), .BAUD(100), .WORD_LENGTH(8), .PARITY_MODE(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .tx_if(if_b), .tx_busy(busy_b), .fifo_count(cnt_b), .UART_TX(tx_b));
    uart_tx_fifo #(.CLKRATE(1000), .BAUD(100), .WORD_LENGTH(8), .PARITY_MODE(0),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_c (
        .clk(clk), .rst(rst), .tx_if(if_c), .tx_busy(busy_c), .fifo_count(cnt_c), .UART_TX(tx_c));

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Bit i of the result is the i-th bit on the line; all three configurations give 11-bit frames.
    function automatic logic [10:0] frame_bits(input int pm, input int sb, input logic [7:0] d);
        logic [10:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        n = 9;
        if (pm != 0) begin
            f[9] = (^d) ^ (pm == 2);
            n = 10;
        end
        for (int s = 0; s < sb; s++) f[n+s] = 1'b1;
        return f;
    endfunction

    typedef struct packed {
        logic [2:0] line;
        logic       sof;
    } sample_t;

    sample_t    q[$];
    int         mcnt     = 0;
    logic [2:0] exp_line = '1;
    logic       exp_busy = 1'b0;
    bit         started  = 0;

    // Each accepted word appends its whole frame, one entry per clock; frames simply queue up.
    always @(posedge clk) begin : model
        bit          acc;
        sample_t     e;
        logic [10:0] fa, fb, fc;
        started = 1;
        if (rst) begin
            q.delete();
            mcnt     = 0;
            exp_line = '1;
            exp_busy = 1'b0;
        end else begin
            acc = valid && (mcnt != DEPTH);
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_line = e.line;
                exp_busy = 1'b1;
                if (e.sof) mcnt--;
            end else begin
                exp_line = '1;
                exp_busy = 1'b0;
            end
            if (acc) begin
                fa = frame_bits(1, 1, data);
                fb = frame_bits(2, 1, data);
                fc = frame_bits(0, 2, data);
                for (int b = 0; b < NBITS; b++)
                    for (int c = 0; c < BDIV; c++)
                        q.push_back('{line: {fc[b], fb[b], fa[b]}, sof: (b == 0 && c == 0)});
                mcnt++;
            end
        end
    end

    task automatic check_dut(input string t, input logic tx, input logic busy,
                             input logic [2:0] cnt, input logic rdy, input int p);
        chk({t, "_line"},  tx,   exp_line[p]);
        chk({t, "_busy"},  busy, exp_busy);
        chk({t, "_count"}, cnt,  mcnt);
        chk({t, "_ready"}, rdy,  (!rst && mcnt != DEPTH));
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_dut("A", tx_a, busy_a, cnt_a, if_a.tx_data_ready, 0);
            check_dut("B", tx_b, busy_b, cnt_b, if_b.tx_data_ready, 1);
            check_dut("C", tx_c, busy_c, cnt_c, if_c.tx_data_ready, 2);
            if (busy_a === 1'b1) busy_cycles++;
        end
    end

    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    task automatic write1(input logic [7:0] d);
        @(posedge clk); #2;
        valid = 1'b1;
        data  = d;
        @(posedge clk); #2;
        valid = 1'b0;
    endtask

    // Holds valid high, advancing to the next word after every accepted edge.
    task automatic send_burst(input int n, output int accepted);
        logic r;
        int idx;
        idx = 0;
        @(posedge clk); #2;
        valid = 1'b1;
        data  = words[0];
        for (int cyc = 0; cyc < 400 && idx < n; cyc++) begin
            @(negedge clk);
            r = if_a.tx_data_ready;
            if (n > DEPTH && cyc == 20) begin
                chk("fifo_full_count", cnt_a, DEPTH);
                chk("accepted_while_full", idx, DEPTH + 1);
            end
            @(posedge clk); #2;
            if (r) begin
                idx++;
                if (idx < n) data = words[idx];
            end
        end
        valid = 1'b0;
        accepted = idx;
    endtask

    initial begin : stim
        logic        cap_a [120];
        logic        cap_b [120];
        logic        cap_c [120];
        logic [10:0] exp_even, exp_odd, exp_a0;
        int          acc, ones, zeros;

        exp_even = 11'b10001101010;
        exp_odd  = 11'b11001101010;
        exp_a0   = 11'b11101000000;

        chk("model_even_35",  frame_bits(1, 1, 8'h35), exp_even);
        chk("model_odd_35",   frame_bits(2, 1, 8'h35), exp_odd);
        chk("model_none2_a0", frame_bits(0, 2, 8'hA0), exp_a0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line",  tx_a, 1);
        chk("rst_busy",  busy_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_ready", if_a.tx_data_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", if_a.tx_data_ready, 1);

        // Single 0x35: even and odd parity frames, bit edges and busy length.
        busy_cycles = 0;
        write1(8'h35);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            cap_a[i] = tx_a;
            cap_b[i] = tx_b;
        end
        chk("A_idle_at_accept", cap_a[0], 1);
        chk("A_start_next_edge", cap_a[1], 0);
        for (int b = 0; b < NBITS; b++) begin
            chk($sformatf("A_bit%0d_first", b), cap_a[1+BDIV*b],  exp_even[b]);
            chk($sformatf("A_bit%0d_last",  b), cap_a[BDIV+BDIV*b], exp_even[b]);
            chk($sformatf("B_bit%0d_mid",   b), cap_b[5+BDIV*b],  exp_odd[b]);
        end
        chk("A_line_after_frame", cap_a[111], 1);
        chk("A_busy_cycles", busy_cycles, 110);

        // 0xA0 on the no-parity, two-stop-bit unit.
        write1(8'hA0);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            cap_c[i] = tx_c;
        end
        for (int b = 0; b < NBITS; b++)
            chk($sformatf("C_bit%0d_mid", b), cap_c[5+BDIV*b], exp_a0[b]);
        ones = 0;
        for (int i = 91; i <= 110; i++) if (cap_c[i] === 1'b1) ones++;
        chk("C_stop_high_cycles", ones, 20);

        // Six words with valid held: FIFO fills, frames run back to back.
        busy_cycles = 0;
        send_burst(6, acc);
        chk("burst_accepted", acc, 6);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (busy_a === 1'b0) break;
        end
        chk("burst_idle", busy_a, 0);
        chk("burst_count_zero", cnt_a, 0);
        chk("burst_busy_cycles", busy_cycles, 6 * 110);

        // Reset during data bit 3 with two words still queued.
        repeat (20) @(posedge clk);
        send_burst(3, acc);
        chk("rst_burst_accepted", acc, 3);
        repeat (42) @(posedge clk);
        #2;
        chk("pre_rst_busy",  busy_a, 1);
        chk("pre_rst_count", cnt_a, 2);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_line",  tx_a, 1);
        chk("post_rst_count", cnt_a, 0);
        chk("post_rst_busy",  busy_a, 0);
        chk("post_rst_ready", if_a.tx_data_ready, 1);
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) zeros++;
        end
        chk("no_residual_bits", zeros, 0);

        busy_cycles = 0;
        write1(8'h5C);
        repeat (120) @(negedge clk);
        chk("fresh_frame_busy", busy_cycles, 110);
        chk("fresh_frame_idle", tx_a, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKRATE, default 100000000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning line rate in bit/s.
REQ-003 The block SHALL have parameter WORD_LENGTH, default 8, meaning data bits per frame (legal 5..9).
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 16, meaning transmit buffer entries (power of two, >=2).
REQ-007 The block SHALL have port clk, input, 1 bit, the clock; all logic SHALL be on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit, the reset; it SHALL be synchronous and active-high.
REQ-009 The block SHALL have port tx_data, input, WORD_LENGTH bits, the word to send.
REQ-010 The block SHALL have port tx_data_valid, input, 1 bit, meaning tx_data is offered.
REQ-011 The block SHALL have port tx_data_ready, output, 1 bit, meaning the FIFO can accept a word.
REQ-012 The block SHALL have port tx_busy, output, 1 bit, meaning a frame is in progress.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits, giving the number of words held.
REQ-014 The block SHALL have port UART_TX, output, 1 bit, the registered serial line output.

Function
REQ-015 BAUD_DIV = CLKRATE/BAUD (integer divide); elaboration SHALL fail if BAUD_DIV<2 or any parameter is outside its legal range.
REQ-016 A word SHALL be written on any edge where tx_data_valid and tx_data_ready are both high; tx_data_ready SHALL equal (fifo_count != FIFO_DEPTH) and SHALL be low while rst is high.
REQ-017 A frame SHALL be 1 start bit (0), WORD_LENGTH data bits LSB first, 1 parity bit if PARITY_MODE!=0, then STOP_BITS stop bits (1).
REQ-018 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-019 Every bit SHALL last exactly BAUD_DIV clock cycles, with no jitter between bits or frames.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-021 Transitions: IDLE->START when FIFO non-empty; START->DATA after 1 bit time; DATA->PARITY (or STOP if PARITY_MODE=0) after WORD_LENGTH bit times; PARITY->STOP after 1 bit time; STOP->START if FIFO non-empty after STOP_BITS bit times, else STOP->IDLE.
REQ-022 Each frame SHALL pop the FIFO head into a shift register on the edge that enters START; the popped word SHALL be unaffected by later writes.
REQ-023 Latency: a word accepted at edge k into an empty FIFO while IDLE SHALL drive UART_TX low from edge k+1.
REQ-024 Back-to-back frames SHALL have zero idle cycles between the last stop bit and the next start bit.
REQ-025 A simultaneous write and pop SHALL leave fifo_count unchanged; a write while full SHALL be impossible (ready low), and a pop while empty SHALL never occur.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH and SHALL preserve order.
REQ-027 tx_busy SHALL be high whenever the FSM is not IDLE; UART_TX SHALL be 1 in IDLE.

Reset
REQ-028 On any edge with rst high, regardless of state: UART_TX=1, tx_busy=0, fifo_count=0, FIFO contents discarded, FSM=IDLE, all counters cleared.
REQ-029 Reset mid-frame SHALL abort the frame with no further bits sent; tx_data_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-030 CLKRATE=1000, BAUD=100 (BAUD_DIV=10), W=8, PARITY_MODE=1, STOP=1, write 0x35 -> UART_TX sequence 0,1,0,1,0,1,1,0,0,0(parity),1, each bit 10 cycles, start at edge k+1, tx_busy high for 110 cycles.
REQ-031 Same configuration with PARITY_MODE=2, write 0x35 -> parity bit 1, all other bits identical.
REQ-032 PARITY_MODE=0, STOP_BITS=2, write 0xA0 -> 0,0,0,0,0,0,1,0,1,1,1; stop bits high for 20 cycles; frame 110 cycles.
REQ-033 FIFO_DEPTH=4, valid held high with 6 distinct words from idle -> 5 accepted, fifo_count reaches 4, ready low until the pop at the start of frame 2; 6 frames sent in order with zero gap; fifo_count returns to 0 and tx_busy drops after the final stop bit.
REQ-034 Assert rst for 1 cycle during DATA bit 3 with 2 words queued -> UART_TX=1 and fifo_count=0 next cycle, no residual bits; a fresh write afterwards produces one complete, correct frame.
